irq_pending_ctrl: RTL and testbench

Interrupt front-end that sits around the 8-to-3 priority encoder (pri_encoder).
- Synchronises 8 asynchronous request lines and detects their rising edges.
- Latches each edge into a pending register and drives the masked pending vector into the encoder.
- Takes the encoder's oe/addr result and presents it to the consumer (CPU/sequencer) over a req/ack handshake.
- Clears the serviced pending bit on acknowledge.

---
 rtl/irq_pending_ctrl_pkg.sv | 12 +
 rtl/irq_pending_ctrl_if.sv | 14 +
 rtl/irq_pending_ctrl_edge_sync.sv | 35 +++
 rtl/irq_pending_ctrl.sv | 101 ++++++++++
 tb/tb_irq_pending_ctrl.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/irq_pending_ctrl_pkg.sv
// Shared constants and FSM state type for the interrupt pending controller.
package irq_pkg;

  localparam int N_SRC = 8;
  localparam int VEC_W = 3;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    REQ  = 1'b1
  } state_t;

endpackage

// File: rtl/irq_pending_ctrl_if.sv
// Consumer-side interrupt handshake: request/vector out, single-cycle ack back.
interface irq_pending_ctrl_if;
  import irq_pkg::*;

  logic             int_req;
  logic [VEC_W-1:0] int_vec;
  logic             int_ack;

  // Controller side drives the request and vector.
  modport master (output int_req, output int_vec, input int_ack);
  // Consumer side (CPU/sequencer) returns the acknowledge.
  modport slave  (input int_req, input int_vec, output int_ack);

endinterface

// File: rtl/irq_pending_ctrl_edge_sync.sv
// Multi-flop synchroniser per request line followed by rising-edge detection.
module irq_edge_sync #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] async_in,
  output logic [WIDTH-1:0] edge_out
);

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] prev_q;

  // Shift the raw lines through the synchroniser chain and keep the last
  // synchronised value for edge comparison; everything clears to 0 so a line
  // held high across reset still yields one event after release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        sync_q[s] <= '0;
      end
      prev_q <= '0;
    end else begin
      sync_q[0] <= async_in;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        sync_q[s] <= sync_q[s-1];
      end
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign edge_out = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/irq_pending_ctrl.sv
// Interrupt front-end: edge capture into pending bits, masked feed to the
// external priority encoder, and req/ack presentation of the chosen vector.
module irq_pending_ctrl
  import irq_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_SRC-1:0] irq_in,
  input  logic [N_SRC-1:0] irq_mask,
  input  logic             glb_en,
  output logic [N_SRC-1:0] enc_din,
  output logic             enc_ena,
  input  logic             enc_oe,
  input  logic [VEC_W-1:0] enc_addr,
  irq_pending_ctrl_if.master cpu,
  output logic [N_SRC-1:0] pending,
  output logic [N_SRC-1:0] ovf,
  input  logic [N_SRC-1:0] ovf_clr
);

  logic [N_SRC-1:0] edge_w;
  logic [N_SRC-1:0] clr_w;
  logic [N_SRC-1:0] pending_q;
  logic [N_SRC-1:0] ovf_q;
  logic [VEC_W-1:0] vec_q;
  state_t           state_q;

  irq_edge_sync #(
    .WIDTH       (N_SRC),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_edge_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .async_in (irq_in),
    .edge_out (edge_w)
  );

  genvar gi;
  generate
    for (gi = 0; gi < N_SRC; gi++) begin : g_src
      // Only the source currently being serviced is cleared by the ack.
      assign clr_w[gi] = (state_q == REQ) && cpu.int_ack && (vec_q == VEC_W'(gi));

      // Pending bit: a new edge wins over a simultaneous clear so no event is lost.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          pending_q[gi] <= 1'b0;
        end else if (edge_w[gi]) begin
          pending_q[gi] <= 1'b1;
        end else if (clr_w[gi]) begin
          pending_q[gi] <= 1'b0;
        end
      end

      // Sticky overflow: an edge on a still-pending source; setting beats clearing.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ovf_q[gi] <= 1'b0;
        end else if (edge_w[gi] && pending_q[gi] && !clr_w[gi]) begin
          ovf_q[gi] <= 1'b1;
        end else if (ovf_clr[gi]) begin
          ovf_q[gi] <= 1'b0;
        end
      end
    end
  endgenerate

  // Handshake FSM: capture the encoder result in IDLE, hold it frozen in REQ
  // until acknowledged; returning to IDLE guarantees a low cycle between requests.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      vec_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (enc_oe) begin
            vec_q   <= enc_addr;
            state_q <= REQ;
          end
        end
        REQ: begin
          if (cpu.int_ack) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign enc_din     = pending_q & irq_mask;
  assign enc_ena     = glb_en;
  assign cpu.int_req = (state_q == REQ);
  assign cpu.int_vec = vec_q;
  assign pending     = pending_q;
  assign ovf         = ovf_q;

endmodule

// File: tb/tb_irq_pending_ctrl.sv
// Directed bench for irq_pending_ctrl: the stimulus queues the expected vector
// of each request, a monitor pops and compares it when int_req rises.
module tb_irq_pending_ctrl;
  import irq_pkg::*;

  logic             clk;
  logic             rst_n;
  logic [N_SRC-1:0] irq_in;
  logic [N_SRC-1:0] irq_mask;
  logic             glb_en;
  logic [N_SRC-1:0] enc_din;
  logic             enc_ena;
  logic             enc_oe;
  logic [VEC_W-1:0] enc_addr;
  logic [N_SRC-1:0] pending;
  logic [N_SRC-1:0] ovf;
  logic [N_SRC-1:0] ovf_clr;

  irq_pending_ctrl_if cpu_if ();

  irq_pending_ctrl #(.SYNC_STAGES(2)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .irq_in   (irq_in),
    .irq_mask (irq_mask),
    .glb_en   (glb_en),
    .enc_din  (enc_din),
    .enc_ena  (enc_ena),
    .enc_oe   (enc_oe),
    .enc_addr (enc_addr),
    .cpu      (cpu_if),
    .pending  (pending),
    .ovf      (ovf),
    .ovf_clr  (ovf_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural 8-to-3 priority encoder standing in for pri_encoder.
  always_comb begin
    enc_oe   = 1'b0;
    enc_addr = '0;
    if (enc_ena) begin
      for (int i = 0; i < N_SRC; i++) begin
        if (enc_din[i]) begin
          enc_oe   = 1'b1;
          enc_addr = VEC_W'(i);
        end
      end
    end
  end

  int n_tests = 0;
  int n_fail  = 0;
  logic [VEC_W-1:0] exp_q[$];
  logic req_prev;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%02h, expected 0x%02h", name, act, exp);
    end else begin
      $display("[TB] ok   %s: 0x%02h", name, act);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_req(input string name);
    int cnt;
    cnt = 0;
    while (cpu_if.int_req !== 1'b1 && cnt < 20) begin
      tick();
      cnt++;
    end
    n_tests++;
    if (cpu_if.int_req !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL %s: int_req not seen within 20 cycles, got %0b expected 1", name, cpu_if.int_req);
    end
  endtask

  task automatic do_ack();
    cpu_if.int_ack = 1'b1;
    tick();
    cpu_if.int_ack = 1'b0;
  endtask

  // Monitor: every rising int_req must match the oldest queued expectation.
  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_prev <= 1'b0;
    end else begin
      if (cpu_if.int_req === 1'b1 && req_prev !== 1'b1) begin
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("[TB] FAIL unexpected_req: got int_vec=%0d, expected no request", cpu_if.int_vec);
        end else begin
          logic [VEC_W-1:0] e;
          e = exp_q.pop_front();
          if (cpu_if.int_vec !== e) begin
            n_fail++;
            $display("[TB] FAIL req_vec: got int_vec=%0d, expected %0d", cpu_if.int_vec, e);
          end else begin
            $display("[TB] ok   req_vec: int_vec=%0d", cpu_if.int_vec);
          end
        end
      end
      req_prev <= cpu_if.int_req;
    end
  end

  initial begin
    rst_n          = 1'b0;
    irq_in         = '0;
    irq_mask       = 8'hFF;
    glb_en         = 1'b1;
    ovf_clr        = '0;
    cpu_if.int_ack = 1'b0;
    tick();
    tick();
    check("rst_pending", pending, 8'h00);
    check("rst_ovf", ovf, 8'h00);
    check("rst_int_req", {7'b0, cpu_if.int_req}, 8'h00);
    check("rst_enc_din", enc_din, 8'h00);
    rst_n = 1'b1;
    tick();

    // Single event on source 5 with latency check.
    irq_in = 8'h20;
    exp_q.push_back(3'd5);
    tick();                                    // edge 0
    check("lat_e0_req", {7'b0, cpu_if.int_req}, 8'h00);
    tick();                                    // edge 1
    check("lat_e1_req", {7'b0, cpu_if.int_req}, 8'h00);
    tick();                                    // edge 2
    irq_in = 8'h00;
    check("lat_e2_pending", pending, 8'h20);
    check("lat_e2_req", {7'b0, cpu_if.int_req}, 8'h00);
    tick();                                    // edge 3
    check("lat_e3_req", {7'b0, cpu_if.int_req}, 8'h01);
    check("lat_e3_vec", {5'b0, cpu_if.int_vec}, 8'h05);
    do_ack();
    check("single_ack_req", {7'b0, cpu_if.int_req}, 8'h00);
    check("single_ack_pending", pending, 8'h00);

    // Sources 1 and 6 together: 6 first, a low gap, then 1.
    irq_in = 8'h42;
    exp_q.push_back(3'd6);
    exp_q.push_back(3'd1);
    wait_req("prio_first");
    check("prio_first_vec", {5'b0, cpu_if.int_vec}, 8'h06);
    do_ack();
    check("prio_gap_req", {7'b0, cpu_if.int_req}, 8'h00);
    check("prio_gap_pending", pending, 8'h02);
    wait_req("prio_second");
    check("prio_second_vec", {5'b0, cpu_if.int_vec}, 8'h01);
    do_ack();
    irq_in = 8'h00;
    tick();
    tick();
    check("prio_done_pending", pending, 8'h00);

    // Masked source stays pending until unmasked.
    irq_mask = 8'hDF;
    irq_in   = 8'h20;
    tick(); tick(); tick();
    irq_in = 8'h00;
    tick(); tick();
    check("mask_pending", pending, 8'h20);
    check("mask_enc_din", enc_din, 8'h00);
    check("mask_no_req", {7'b0, cpu_if.int_req}, 8'h00);
    exp_q.push_back(3'd5);
    irq_mask = 8'hFF;
    wait_req("mask_release");
    do_ack();
    check("mask_done_pending", pending, 8'h00);

    // Ack collides with a fresh edge on the serviced source.
    irq_in = 8'h08;
    exp_q.push_back(3'd3);
    wait_req("coll_first");
    irq_in = 8'h00;
    tick(); tick(); tick();
    irq_in = 8'h08;
    exp_q.push_back(3'd3);
    tick();                                    // sampled
    tick();                                    // edge visible during next cycle
    do_ack();                                  // ack lands with the edge
    check("coll_pending", pending, 8'h08);
    check("coll_ovf", ovf, 8'h00);
    check("coll_gap_req", {7'b0, cpu_if.int_req}, 8'h00);
    wait_req("coll_second");
    check("coll_second_vec", {5'b0, cpu_if.int_vec}, 8'h03);
    do_ack();
    irq_in = 8'h00;
    tick();
    check("coll_done_pending", pending, 8'h00);

    // Two edges on source 2 without ack -> overflow, then clear it.
    irq_in = 8'h04;
    exp_q.push_back(3'd2);
    tick(); tick(); tick();
    irq_in = 8'h00;
    tick(); tick(); tick();
    irq_in = 8'h04;
    tick(); tick(); tick();
    irq_in = 8'h00;
    tick();
    check("ovf_set", ovf, 8'h04);
    check("ovf_pending", pending, 8'h04);
    ovf_clr = 8'h04;
    tick();
    ovf_clr = 8'h00;
    check("ovf_cleared", ovf, 8'h00);
    wait_req("ovf_req");
    do_ack();
    check("ovf_done_pending", pending, 8'h00);

    // glb_en low gates the encoder enable.
    glb_en = 1'b0;
    #1;
    check("enc_ena_off", {7'b0, enc_ena}, 8'h00);
    glb_en = 1'b1;
    tick();

    // Reset while a request is outstanding clears everything without a clock.
    irq_in = 8'h81;
    exp_q.push_back(3'd7);
    wait_req("rst_mid_req");
    irq_in = 8'h00;
    tick(); tick(); tick();
    irq_in = 8'h01;
    tick(); tick(); tick();
    check("rst_mid_ovf_before", ovf, 8'h01);
    check("rst_mid_pending_before", pending, 8'h81);
    rst_n = 1'b0;
    #2;
    check("rst_mid_req", {7'b0, cpu_if.int_req}, 8'h00);
    check("rst_mid_pending", pending, 8'h00);
    check("rst_mid_ovf", ovf, 8'h00);
    irq_in = 8'h00;
    tick();
    rst_n = 1'b1;
    tick(); tick(); tick(); tick();
    check("final_no_req", {7'b0, cpu_if.int_req}, 8'h00);
    check("final_queue_empty", 8'(exp_q.size()), 8'h00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
